// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ARM condition codes, NZCV bit positions and
// the decoder flag-write select type.
package cpu_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;

  // [1] selects N,Z ; [0] selects C,V
  typedef logic [1:0] flagw_t;

endpackage

// File: rtl/cond_unit_cond_check.sv
// cond_check: pure combinational evaluation of an ARM condition field
// against a {N,Z,C,V} flag vector. NV (1111) never passes.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n_s, z_s, c_s, v_s;

  assign n_s = flags[N_IDX];
  assign z_s = flags[Z_IDX];
  assign c_s = flags[C_IDX];
  assign v_s = flags[V_IDX];

  // Decode the condition field into a pass/fail decision
  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      EQ:      pass = z_s;
      NE:      pass = ~z_s;
      CS:      pass = c_s;
      CC:      pass = ~c_s;
      MI:      pass = n_s;
      PL:      pass = ~n_s;
      VS:      pass = v_s;
      VC:      pass = ~v_s;
      HI:      pass = c_s & ~z_s;
      LS:      pass = ~c_s | z_s;
      GE:      pass = (n_s == v_s);
      LT:      pass = (n_s != v_s);
      GT:      pass = ~z_s & (n_s == v_s);
      LE:      pass = z_s | (n_s != v_s);
      AL:      pass = 1'b1;
      NV:      pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// cond_unit: execute-stage condition/flag unit. Holds architectural NZCV,
// gates PCSrc/RegWrite/MemWrite on the condition result and squashes the
// BR_SHADOW wrong-path valid slots that follow a taken branch.
// Optional feature macro: COND_PERF_CNT_EN adds ExecCount/SquashCount.
module cond_unit
  import cpu_pkg::*;
#(
  parameter int BR_SHADOW = 2,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             valid,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
`ifdef COND_PERF_CNT_EN
  output logic [CNT_W-1:0] ExecCount,
  output logic [CNT_W-1:0] SquashCount,
`endif
  output logic [3:0]       Flags
);

  typedef enum logic {
    RUN    = 1'b0,
    SHADOW = 1'b1
  } state_e;

  localparam logic [2:0] SHADOW_INIT = 3'(BR_SHADOW);

  state_e     state_r, state_nxt_s;
  logic [2:0] count_r, count_nxt_s;
  logic [3:0] flags_r, flags_nxt_s;
  logic       cond_pass_s;
  logic       cond_ex_s;
  logic       pcsrc_s;
  flagw_t     flagw_s;

  assign flagw_s = FlagW;

  cond_check u_cond_check (
    .cond  (Cond),
    .flags (flags_r),
    .pass  (cond_pass_s)
  );

  // Execute decision and gated write strobes, all zero-latency
  always_comb begin
    cond_ex_s = reset_n & en & valid & (state_r == RUN) & cond_pass_s;
    pcsrc_s   = PCS & cond_ex_s;
    PCSrc     = pcsrc_s;
    RegWrite  = RegW & ~NoWrite & cond_ex_s;
    MemWrite  = MemW & cond_ex_s;
    CondEx    = cond_ex_s;
    Flags     = flags_r;
  end

  // Shadow FSM next state: open the shadow on a taken branch, consume it on valid slots
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    case (state_r)
      RUN: begin
        if (en && pcsrc_s) begin
          state_nxt_s = SHADOW;
          count_nxt_s = SHADOW_INIT;
        end else begin
          state_nxt_s = RUN;
        end
      end
      SHADOW: begin
        if (en && valid) begin
          if (count_r <= 3'd1) begin
            state_nxt_s = RUN;
            count_nxt_s = 3'd0;
          end else begin
            count_nxt_s = count_r - 3'd1;
          end
        end else begin
          count_nxt_s = count_r;
        end
      end
      default: begin
        state_nxt_s = RUN;
        count_nxt_s = 3'd0;
      end
    endcase
  end

  // Flag next value: only executing instructions update the selected halves
  always_comb begin
    flags_nxt_s = flags_r;
    if (cond_ex_s) begin
      if (flagw_s[1]) begin
        flags_nxt_s[N_IDX] = ALUFlags[N_IDX];
        flags_nxt_s[Z_IDX] = ALUFlags[Z_IDX];
      end else begin
        flags_nxt_s[N_IDX] = flags_r[N_IDX];
        flags_nxt_s[Z_IDX] = flags_r[Z_IDX];
      end
      if (flagw_s[0]) begin
        flags_nxt_s[C_IDX] = ALUFlags[C_IDX];
        flags_nxt_s[V_IDX] = ALUFlags[V_IDX];
      end else begin
        flags_nxt_s[C_IDX] = flags_r[C_IDX];
        flags_nxt_s[V_IDX] = flags_r[V_IDX];
      end
    end else begin
      flags_nxt_s = flags_r;
    end
  end

  // State, shadow count and flag registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= RUN;
      count_r <= 3'd0;
      flags_r <= 4'b0000;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      flags_r <= flags_nxt_s;
    end
  end

`ifdef COND_PERF_CNT_EN
  // Performance counters: executed and squashed valid slots, wrapping silently
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ExecCount   <= {CNT_W{1'b0}};
      SquashCount <= {CNT_W{1'b0}};
    end else begin
      if (cond_ex_s) begin
        ExecCount <= ExecCount + CNT_W'(1);
      end else begin
        ExecCount <= ExecCount;
      end
      if (en && valid && !cond_ex_s) begin
        SquashCount <= SquashCount + CNT_W'(1);
      end else begin
        SquashCount <= SquashCount;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: the stimulus process pushes the expected
// strobes/flags for each driven cycle; a monitor pops and compares on negedge.
module tb_cond_unit;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic       valid;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite;
  logic       PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0] Flags;
`ifdef COND_PERF_CNT_EN
  logic [31:0] ExecCount, SquashCount;
`endif

  cond_unit #(.BR_SHADOW(2), .CNT_W(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .valid    (valid),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
    .NoWrite  (NoWrite),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .CondEx   (CondEx),
`ifdef COND_PERF_CNT_EN
    .ExecCount   (ExecCount),
    .SquashCount (SquashCount),
`endif
    .Flags    (Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] exp; // {CondEx, PCSrc, RegWrite, MemWrite, Flags}
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  // Independent truth table for the condition sweep
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cc, v;
    n = f[3]; z = f[2]; cc = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cc;
      4'd3:  return !cc;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cc && !z;
      4'd9:  return !(cc && !z);
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return !(!z && (n == v));
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Drive one cycle of inputs after the edge; optionally queue the expected response
  task automatic step(input bit chk, input string name,
                      input logic rn, input logic e, input logic v,
                      input logic [3:0] c, input logic [3:0] af, input logic [1:0] fw,
                      input logic pcs, input logic rw, input logic mw, input logic nw,
                      input logic [7:0] exp);
    exp_t t;
    @(posedge clk);
    #1;
    reset_n = rn; en = e; valid = v; Cond = c; ALUFlags = af; FlagW = fw;
    PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw;
    if (chk) begin
      t.name = name;
      t.exp  = exp;
      sb.push_back(t);
    end
  endtask

  // Monitor: compare DUT outputs against the queued expectation each cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t t;
      logic [7:0] act;
      t   = sb.pop_front();
      act = {CondEx, PCSrc, RegWrite, MemWrite, Flags};
      checks++;
      if (act === t.exp) passes++;
      else $display("FAIL %s: got {CondEx,PCSrc,RegWrite,MemWrite,Flags}=%b_%b required %b_%b",
                    t.name, act[7:4], act[3:0], t.exp[7:4], t.exp[3:0]);
    end
  end

  initial begin
    reset_n = 1'b0; en = 1'b1; valid = 1'b0; Cond = 4'he; ALUFlags = 4'h0;
    FlagW = 2'b00; PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;

    // 1 reset
    step(1'b0, "rst0",    1'b0, 1'b1, 1'b1, 4'he, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, "rst1",    1'b0, 1'b1, 1'b1, 4'he, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 8'b0000_0000);
    step(1'b1, "rst_rel", 1'b1, 1'b1, 1'b1, 4'he, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 8'b1010_0000);
    // 2 CMP equal
    step(1'b1, "cmp",     1'b1, 1'b1, 1'b1, 4'he, 4'h6, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 8'b1000_0000);
    step(1'b1, "eq_pass", 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 8'b1001_0110);
    step(1'b1, "ne_fail", 1'b1, 1'b1, 1'b1, 4'h1, 4'h0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 8'b0000_0110);
    // 3 partial write
    step(1'b1, "load1011",1'b1, 1'b1, 1'b1, 4'he, 4'hb, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'b1000_0110);
    step(1'b1, "nz_only", 1'b1, 1'b1, 1'b1, 4'he, 4'h4, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 8'b1000_1011);
    step(1'b1, "cv_kept", 1'b1, 1'b1, 1'b1, 4'he, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'b1000_0111);
    // failing instruction must not touch flags
    step(1'b1, "fail_nowr",1'b1,1'b1, 1'b1, 4'h1, 4'h0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 8'b0000_0111);
    step(1'b1, "fail_held",1'b1,1'b1, 1'b1, 4'he, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'b1000_0111);

    // 4 sweep: load each flag value, then try all 16 conditions
    begin
      logic [3:0] prev;
      prev = 4'b0111;
      for (int f = 0; f < 16; f++) begin
        step(1'b1, "sweep_ld", 1'b1, 1'b1, 1'b1, 4'he, 4'(f), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0,
             {4'b1000, prev});
        for (int c = 0; c < 16; c++) begin
          step(1'b1, "sweep", 1'b1, 1'b1, 1'b1, 4'(c), 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0,
               {ref_pass(4'(c), 4'(f)), 1'b0, ref_pass(4'(c), 4'(f)), 1'b0, 4'(f)});
        end
        prev = 4'(f);
      end
    end

    // 5 taken branch, flags now 1111
    step(1'b1, "br_taken", 1'b1, 1'b1, 1'b1, 4'he, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'b1100_1111);
    step(1'b1, "shadow1",  1'b1, 1'b1, 1'b1, 4'he, 4'h0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 8'b0000_1111);
    step(1'b1, "bubble",   1'b1, 1'b1, 1'b0, 4'he, 4'h0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 8'b0000_1111);
    step(1'b1, "shadow2",  1'b1, 1'b1, 1'b1, 4'he, 4'h0, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 8'b0000_1111);
    step(1'b1, "post_sh",  1'b1, 1'b1, 1'b1, 4'he, 4'h0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 8'b1011_1111);

    // 6 stall inside shadow and in RUN
    step(1'b1, "br2",      1'b1, 1'b1, 1'b1, 4'he, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'b1100_1111);
    step(1'b1, "stall_sh", 1'b1, 1'b0, 1'b1, 4'he, 4'hf, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 8'b0000_1111);
    step(1'b1, "sh_a",     1'b1, 1'b1, 1'b1, 4'he, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 8'b0000_1111);
    step(1'b1, "stall_sh2",1'b1, 1'b0, 1'b1, 4'he, 4'h0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 8'b0000_1111);
    step(1'b1, "sh_b",     1'b1, 1'b1, 1'b1, 4'he, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 8'b0000_1111);
    step(1'b1, "sh_done",  1'b1, 1'b1, 1'b1, 4'he, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 8'b1010_1111);
    step(1'b1, "stall_run",1'b1, 1'b0, 1'b1, 4'he, 4'h0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 8'b0000_1111);
    step(1'b1, "after_st", 1'b1, 1'b1, 1'b1, 4'he, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'b1000_1111);

    // reset in the middle of a shadow
    step(1'b1, "br3",      1'b1, 1'b1, 1'b1, 4'he, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'b1100_1111);
    step(1'b1, "sh_c",     1'b1, 1'b1, 1'b1, 4'he, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 8'b0000_1111);
    step(1'b1, "rst_mid",  1'b0, 1'b1, 1'b1, 4'he, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 8'b0000_1111);
    step(1'b1, "run_again",1'b1, 1'b1, 1'b1, 4'he, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 8'b1010_0000);

    // drain the scoreboard with a bounded wait
    begin
      int budget;
      budget = 20;
      while (sb.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (sb.size() > 0) begin
        checks++;
        $display("FAIL drain: %0d entries left, required 0", sb.size());
      end
    end
    @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
